// File: rtl/uc_sequencer_if.sv
// Datapath-facing bundle between the microc datapath and its control sequencer.
// master = sequencer (drives strobes), slave = datapath (drives Opcode and z).
interface uc_sequencer_if;
  logic [5:0] Opcode;
  logic       z;
  logic       s_inc;
  logic       s_inm;
  logic       we3;
  logic       wez;
  logic [2:0] Op;
  logic       pc_we;

  modport master (input Opcode, z, output s_inc, s_inm, we3, wez, Op, pc_we);
  modport slave  (output Opcode, z, input s_inc, s_inm, we3, wez, Op, pc_we);
endinterface

// File: rtl/uc_sequencer.sv
// Multi-cycle FETCH/EXEC control unit for microc with run/step/halt control,
// illegal-opcode trap and a saturating retired-instruction counter.
module uc_sequencer #(
  parameter int         CNT_W   = 16,
  parameter logic [5:0] HALT_OP = 6'b011111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  uc_sequencer_if.master   dp,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, HALT, ERR} state_t;

  state_t           state_q, state_d;
  logic [5:0]       ir_q, ir_d;
  logic             step_prev_q, step_prev_d;
  logic             one_shot_q, one_shot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       s_inc, s_inm, we3, wez, pc_we, legal;
  logic [2:0] op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      step_prev_q <= 1'b0;
      one_shot_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      step_prev_q <= step_prev_d;
      one_shot_q  <= one_shot_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    step_prev_d = step;
    one_shot_d  = one_shot_q;
    cnt_d       = cnt_q;
    s_inc       = 1'b1;
    s_inm       = 1'b0;
    we3         = 1'b0;
    wez         = 1'b0;
    op          = 3'b000;
    pc_we       = 1'b0;
    legal       = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d    = FETCH;
          one_shot_d = 1'b0;
        end else if (step && !step_prev_q) begin
          state_d    = FETCH;
          one_shot_d = 1'b1;
        end
      end
      FETCH: begin
        ir_d    = dp.Opcode;
        state_d = EXEC;
      end
      EXEC: begin
        legal = 1'b1;
        if (ir_q[5]) begin
          op    = ir_q[4:2];
          we3   = 1'b1;
          wez   = 1'b1;
          pc_we = 1'b1;
        end else if (ir_q == 6'b000000) begin
          pc_we = 1'b1;
        end else if (ir_q[5:2] == 4'b0001) begin
          we3   = 1'b1;
          s_inm = 1'b1;
          pc_we = 1'b1;
        end else if (ir_q == 6'b010000) begin
          s_inc = 1'b0;
          pc_we = 1'b1;
        end else if (ir_q == 6'b010001) begin
          s_inc = ~dp.z;
          pc_we = 1'b1;
        end else if (ir_q == 6'b010010) begin
          s_inc = dp.z;
          pc_we = 1'b1;
        end else begin
          legal   = 1'b0;
          state_d = (ir_q == HALT_OP) ? HALT : ERR;
        end

        if (legal) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          // A stepped instruction always drops back to IDLE, even if run rose meanwhile.
          if (run && !one_shot_q) begin
            state_d = FETCH;
          end else begin
            state_d    = IDLE;
            one_shot_d = 1'b0;
          end
        end
      end
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  assign dp.s_inc    = s_inc;
  assign dp.s_inm    = s_inm;
  assign dp.we3      = we3;
  assign dp.wez      = wez;
  assign dp.Op       = op;
  assign dp.pc_we    = pc_we;
  assign halted      = (state_q == HALT);
  assign illegal     = (state_q == ERR);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_uc_sequencer.sv
// Directed bench for uc_sequencer: single-step decode table plus hand-written
// run, step-hold, halt, illegal, reset-mid-EXEC and counter-saturation sequences.
module tb_uc_sequencer;
  logic        clk = 1'b0;
  logic        reset, run, step;
  logic        reset1, run1, step1;
  logic        halted, illegal, halted1, illegal1;
  logic [15:0] cnt;
  logic [1:0]  cnt1;

  uc_sequencer_if dp0 ();
  uc_sequencer_if dp1 ();

  uc_sequencer #(.CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .run(run), .step(step), .dp(dp0),
    .halted(halted), .illegal(illegal), .instr_count(cnt)
  );

  uc_sequencer #(.CNT_W(2)) u1 (
    .clk(clk), .reset(reset1), .run(run1), .step(step1), .dp(dp1),
    .halted(halted1), .illegal(illegal1), .instr_count(cnt1)
  );

  always #5 clk = ~clk;

  // {s_inc, s_inm, we3, wez, Op[2:0], pc_we}
  logic [7:0] obs;
  assign obs = {dp0.s_inc, dp0.s_inm, dp0.we3, dp0.wez, dp0.Op, dp0.pc_we};
  localparam logic [7:0] QUIET = 8'b1_0_0_0_000_0;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int pulses, pulse_cyc;
    vecs[0] = '{6'b100100, 1'b0, 8'b1_0_1_1_001_1, "alu_op001"};
    vecs[1] = '{6'b111101, 1'b1, 8'b1_0_1_1_111_1, "alu_op111"};
    vecs[2] = '{6'b000101, 1'b0, 8'b1_1_1_0_000_1, "li"};
    vecs[3] = '{6'b000000, 1'b0, 8'b1_0_0_0_000_1, "nop"};
    vecs[4] = '{6'b010000, 1'b0, 8'b0_0_0_0_000_1, "j"};
    vecs[5] = '{6'b010001, 1'b1, 8'b0_0_0_0_000_1, "jz_z1"};
    vecs[6] = '{6'b010001, 1'b0, 8'b1_0_0_0_000_1, "jz_z0"};
    vecs[7] = '{6'b010010, 1'b0, 8'b0_0_0_0_000_1, "jnz_z0"};
    vecs[8] = '{6'b010010, 1'b1, 8'b1_0_0_0_000_1, "jnz_z1"};

    reset = 1'b0; run = 1'b0; step = 1'b0;
    reset1 = 1'b0; run1 = 1'b0; step1 = 1'b0;
    dp0.Opcode = 6'd0; dp0.z = 1'b0;
    dp1.Opcode = 6'd0; dp1.z = 1'b0;

    // Reset / idle
    tick(); tick();
    chk("rst_outs", obs, QUIET);
    chk("rst_cnt", cnt, 0);
    chk("rst_flags", {halted, illegal}, 2'b00);
    reset = 1'b1; reset1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_outs", obs, QUIET);
      chk("idle_cnt", cnt, 0);
    end

    // Decode table, one stepped instruction per entry
    for (int i = 0; i < 9; i++) begin
      dp0.Opcode = vecs[i].op; dp0.z = vecs[i].z;
      step = 1'b1; tick();
      chk({vecs[i].name, "_fetch"}, obs, QUIET);
      step = 1'b0; tick();
      chk({vecs[i].name, "_exec"}, obs, vecs[i].exp);
      tick();
      chk({vecs[i].name, "_after"}, obs, QUIET);
      chk({vecs[i].name, "_cnt"}, cnt, i + 1);
    end
    dp0.z = 1'b0;

    // Run mode: ALU, li, nop back to back
    run = 1'b1; dp0.Opcode = 6'b100100;
    tick(); chk("run_f1", obs, QUIET);
    tick(); chk("run_e1", obs, 8'b1_0_1_1_001_1);
    dp0.Opcode = 6'b000111;
    tick(); chk("run_f2", obs, QUIET);
    tick(); chk("run_e2", obs, 8'b1_1_1_0_000_1);
    dp0.Opcode = 6'b000000;
    tick(); chk("run_f3", obs, QUIET);
    tick(); chk("run_e3", obs, 8'b1_0_0_0_000_1);
    run = 1'b0;
    tick(); chk("run_stop1", obs, QUIET);
    tick(); chk("run_stop2", obs, QUIET);
    chk("run_cnt", cnt, 12);

    // run dropped during FETCH still completes the instruction
    run = 1'b1;
    tick(); run = 1'b0;
    tick(); chk("rundrop_exec", obs, 8'b1_0_0_0_000_1);
    tick(); chk("rundrop_idle1", obs, QUIET);
    tick(); chk("rundrop_idle2", obs, QUIET);
    chk("rundrop_cnt", cnt, 13);

    // step held high: exactly one instruction
    dp0.Opcode = 6'b100000;
    step = 1'b1; pulses = 0; pulse_cyc = -1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (dp0.pc_we) begin pulses++; pulse_cyc = c; end
    end
    step = 1'b0;
    chk("hold_pulses", pulses, 1);
    chk("hold_latency", pulse_cyc, 2);
    chk("hold_cnt", cnt, 14);
    tick(); chk("hold_idle", obs, QUIET);

    // Reset mid-EXEC on li: strobes drop asynchronously
    dp0.Opcode = 6'b000111;
    step = 1'b1; tick(); step = 1'b0; tick();
    chk("rstmid_we3_pre", dp0.we3, 1'b1);
    #2 reset = 1'b0;
    #1 chk("rstmid_outs", obs, QUIET);
    chk("rstmid_cnt", cnt, 0);
    tick(); reset = 1'b1;
    tick(); chk("rstmid_idle", obs, QUIET);

    // Halt opcode
    dp0.Opcode = 6'b011111;
    step = 1'b1; tick(); step = 1'b0; tick();
    chk("halt_exec", obs, QUIET);
    tick();
    chk("halt_flags", {halted, illegal}, 2'b10);
    run = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step = c[0];
      tick();
      if (dp0.pc_we || dp0.we3 || dp0.wez) pulses++;
    end
    run = 1'b0; step = 1'b0;
    chk("halt_nostrobe", pulses, 0);
    chk("halt_sticky", {halted, illegal}, 2'b10);
    chk("halt_cnt", cnt, 0);

    // Illegal opcode after a fresh reset
    reset = 1'b0; tick(); reset = 1'b1;
    chk("ill_clear", {halted, illegal}, 2'b00);
    dp0.Opcode = 6'b001000;
    step = 1'b1; tick(); step = 1'b0; tick();
    chk("ill_exec", obs, QUIET);
    tick();
    chk("ill_flags", {halted, illegal}, 2'b01);
    run = 1'b1; tick(); tick();
    chk("ill_sticky", {obs, halted, illegal}, {QUIET, 2'b01});
    chk("ill_cnt", cnt, 0);
    run = 1'b0;

    // Saturation on the 2-bit counter instance with nops
    run1 = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    chk("sat_mid", cnt1, 2'd2);
    for (int c = 0; c < 7; c++) tick();
    run1 = 1'b0;
    tick(); tick();
    chk("sat_final", cnt1, 2'd3);
    chk("sat_flags", {halted1, illegal1}, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uc_sequencer.md
Name: uc_sequencer

Overview:
- Multi-cycle control unit for the microc datapath. Drives s_inc, s_inm, we3, wez, Op from the datapath's Opcode and z outputs.
- Adds a PC write enable so the datapath advances only when an instruction executes.
- Supports run, single-step and halt, detects illegal opcodes and counts retired instructions.
- Instantiated beside microc at cpu top level.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- HALT_OP, 6'b011111, opcode that stops the core

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low (reset=0 clears everything immediately)
- Opcode  in  6  instruction opcode from datapath (memory at current PC)
- z  in  1  zero flag from datapath
- run  in  1  level: 1 = free-running execution
- step  in  1  single-step request; acted on at its rising edge (internally edge-detected)
- s_inc  out  1  PC mux: 1 = PC+1, 0 = jump target
- s_inm  out  1  register-file write-data mux: 1 = immediate, 0 = ALU
- we3  out  1  register-file write enable
- wez  out  1  zero-flag write enable
- Op  out  3  ALU operation
- pc_we  out  1  PC load enable
- halted  out  1  core stopped on HALT_OP
- illegal  out  1  core stopped on undefined opcode
- instr_count  out  CNT_W  retired instructions

Behaviour:
- States: IDLE, FETCH, EXEC, HALT, ERR. Reset enters IDLE.
- Reset values:
  - state = IDLE, ir = 0, step_d = 0, instr_count = 0
  - s_inc = 1, s_inm = 0, we3 = 0, wez = 0, Op = 000, pc_we = 0
  - halted = 0, illegal = 0
- IDLE:
  - run=1 goes to FETCH.
  - Otherwise a step rising edge (step & ~step_d) goes to FETCH with one-shot flag set.
  - Otherwise stay in IDLE.
- FETCH:
  - ir <= Opcode.
  - All write strobes and pc_we are 0.
  - Next state is EXEC.
- EXEC: decode ir, combinational from state, ir and live z.
  - ALU op (1xxxxx): Op = ir[4:2], we3 = 1, wez = 1, s_inm = 0, s_inc = 1, pc_we = 1.
  - nop (000000): pc_we = 1, s_inc = 1, no writes.
  - li (0001xx): we3 = 1, s_inm = 1, s_inc = 1, pc_we = 1.
  - j (010000): s_inc = 0, pc_we = 1.
  - jz (010001): s_inc = ~z, pc_we = 1 (jump taken when z=1).
  - jnz (010010): s_inc = z, pc_we = 1 (jump taken when z=0).
  - ir == HALT_OP: no strobes, pc_we = 0; next state HALT.
  - Any other opcode: no strobes, pc_we = 0; next state ERR.
  - Legal opcode: instr_count += 1, saturating at all-ones.
  - Next state after a legal opcode: FETCH if run=1 and no one-shot flag; otherwise IDLE (one-shot flag cleared).
- Outside EXEC: s_inc = 1, s_inm = 0, we3 = 0, wez = 0, Op = 000, pc_we = 0.
- HALT: halted = 1; sticky until reset. run and step are ignored.
- ERR: illegal = 1; sticky until reset. run and step are ignored.
- Throughput: 2 cycles per instruction in run mode.
- Latency: step edge to pc_we pulse is 2 cycles (IDLE→FETCH→EXEC).
- run deasserted during FETCH: the instruction still completes in EXEC, then the core goes to IDLE.
- step while run=1: ignored.
- step held high: only one instruction executes.
- Reset asserted mid-EXEC: strobes drop to 0 asynchronously, so no register-file write occurs on that edge.
- Strobes are single-cycle; wez and we3 are never asserted outside EXEC.

Test Plan:
- Reset/idle:
  - Stimulus: reset=0 for 2 cycles, then reset=1 with run=0, step=0 for 5 cycles.
  - Required: state IDLE, pc_we = 0, we3 = 0, wez = 0, s_inc = 1, instr_count = 0 throughout.
- Run-mode decode:
  - Stimulus: run=1, Opcode sequence 100100 (ALU Op=001), 000111 (li), 000000 (nop).
  - Required EXEC cycle 1: we3 = 1, wez = 1, Op = 001.
  - Required EXEC cycle 2: we3 = 1, s_inm = 1.
  - Required EXEC cycle 3: only pc_we = 1.
  - Required: pc_we pulses every 2nd cycle; instr_count = 3.
- Conditional jumps:
  - jz with z=1 → s_inc = 0, pc_we = 1.
  - jz with z=0 → s_inc = 1.
  - jnz with z=0 → s_inc = 0.
  - jnz with z=1 → s_inc = 1.
  - j → s_inc = 0.
- Single step:
  - Stimulus: run=0, step held high 6 cycles with Opcode 100000.
  - Required: exactly one pc_we pulse, 2 cycles after the edge; instr_count = 1; back in IDLE.
- Halt and illegal:
  - Opcode 011111 → halted = 1 after EXEC, pc_we stays 0, instr_count unchanged; run/step then ignored.
  - After a new reset, Opcode 001000 → illegal = 1, no strobes.
- Counter saturation and reset mid-op:
  - Stimulus: CNT_W=2 with 5 nops.
  - Required: instr_count = 3.
  - Stimulus: reset=0 during an EXEC with li.
  - Required: we3 falls before the next clock edge; state IDLE.
